// File: rtl/processor_pkg.sv
// Shared definitions for the multicycle processor: opcodes, FSM state encoding
// and the sign-extension helper used for immediates and jump offsets.
package processor_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_SLT  = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JMP  = 3'b111;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    // Sign-extends the low 'width' bits of val to 32 bits; callers size-cast the result.
    function automatic logic [31:0] sext(input logic [31:0] val, input int unsigned width);
        logic [31:0] hi;
        hi = 32'hFFFF_FFFF << width;
        if ((val & (32'd1 << (width - 1))) != 32'd0)
            return val | hi;
        else
            return val & ~hi;
    endfunction

endpackage

// File: rtl/param_reg_file.sv
// Register file: 2**RA_W x DATA_W, two asynchronous read ports, one synchronous
// write port, synchronous active-high reset clearing every entry.
module param_reg_file
#(
    parameter int DATA_W = 8,
    parameter int RA_W   = 1
)
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_we,
    input  logic [RA_W-1:0]   i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [RA_W-1:0]   i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [RA_W-1:0]   i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_regs [2**RA_W];

    // NOTE: the array is small and architecturally visible, so every entry is reset; large RAMs normally are not.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 2**RA_W; i++)
                r_regs[i] <= '0;
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_regs[i_raddr_a];
    assign o_rdata_b = r_regs[i_raddr_b];

endmodule

// File: rtl/multicycle_processor.sv
// Multicycle processor: FETCH/DECODE/EXEC/MEM/WB FSM with req/ack instruction and data ports.
// Optional macro PERF_CNT_EN adds cycle_cnt and retired_cnt performance counters.
module multicycle_processor
    import processor_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int PC_W    = 8,
    parameter  int RA_W    = 1,
    parameter  int IMM_W   = 3,
    localparam int INSTR_W = 3 + 2*RA_W + IMM_W
)
(
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DATA_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ack,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic [PC_W-1:0]    pc_out,
    output logic               halted
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        retired_cnt
`endif
);

    logic [2:0]         r_state;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_next_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [DATA_W-1:0]  r_op_a;
    logic [DATA_W-1:0]  r_op_b;
    logic [DATA_W-1:0]  r_result;
    logic [DATA_W-1:0]  r_addr;

    logic [2:0]           w_op;
    logic [RA_W-1:0]      w_rd;
    logic [RA_W-1:0]      w_rs;
    logic [IMM_W-1:0]     w_imm_raw;
    logic [INSTR_W-4:0]   w_off_raw;
    logic [DATA_W-1:0]    w_imm;
    logic [PC_W-1:0]      w_imm_pc;
    logic [PC_W-1:0]      w_off_pc;
    logic [DATA_W-1:0]    w_rd_val;
    logic [DATA_W-1:0]    w_rs_val;
    logic [DATA_W-1:0]    w_alu;
    logic [PC_W-1:0]      w_target;
    logic                 w_rf_we;

    assign w_op      = r_instr[INSTR_W-1 -: 3];
    assign w_rd      = r_instr[INSTR_W-4 -: RA_W];
    assign w_rs      = r_instr[IMM_W +: RA_W];
    assign w_imm_raw = r_instr[IMM_W-1:0];
    assign w_off_raw = r_instr[INSTR_W-4:0];
    assign w_imm     = DATA_W'(sext(32'(w_imm_raw), IMM_W));
    assign w_imm_pc  = PC_W'(sext(32'(w_imm_raw), IMM_W));
    assign w_off_pc  = PC_W'(sext(32'(w_off_raw), INSTR_W - 3));

    assign w_rf_we = (r_state == S_WB) &&
                     (w_op == OP_ADD || w_op == OP_SUB || w_op == OP_ADDI ||
                      w_op == OP_SLT || w_op == OP_LW);

    param_reg_file #(.DATA_W(DATA_W), .RA_W(RA_W)) u_reg_file (
        .i_clk     (clock),
        .i_reset   (reset),
        .i_we      (w_rf_we),
        .i_waddr   (w_rd),
        .i_wdata   (r_result),
        .i_raddr_a (w_rd),
        .o_rdata_a (w_rd_val),
        .i_raddr_b (w_rs),
        .o_rdata_b (w_rs_val)
    );

    // NOTE: every path assigns a default first so this block can never infer a latch.
    always_comb begin
        w_alu    = r_op_a;
        w_target = r_pc + PC_W'(1);
        case (w_op)
            OP_ADD:  w_alu = r_op_a + r_op_b;
            OP_SUB:  w_alu = r_op_a - r_op_b;
            OP_ADDI: w_alu = r_op_a + w_imm;
            OP_SLT:  w_alu = DATA_W'($signed(r_op_a) < $signed(r_op_b));
            OP_BEQ:  if (r_op_a == r_op_b) w_target = r_pc + w_imm_pc;
            OP_JMP:  w_target = r_pc + w_off_pc;
            default: w_alu = r_op_a;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_pc      <= '0;
            r_next_pc <= '0;
            r_instr   <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_result  <= '0;
            r_addr    <= '0;
        end else begin
            case (r_state)
                S_FETCH: if (imem_ack) begin
                    r_instr <= imem_rdata;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_op_a  <= w_rd_val;
                    r_op_b  <= w_rs_val;
                    r_state <= (w_op == OP_JMP && w_off_raw == '0) ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    r_result  <= w_alu;
                    r_addr    <= r_op_b + w_imm;
                    r_next_pc <= w_target;
                    r_state   <= (w_op == OP_LW || w_op == OP_SW) ? S_MEM : S_WB;
                end
                S_MEM: if (dmem_ack) begin
                    if (w_op == OP_LW) r_result <= dmem_rdata;
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_pc    <= r_next_pc;
                    r_state <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // FETCH is also the reset state, so the fetch request is masked while reset is held.
    assign imem_req   = (r_state == S_FETCH) && !reset;
    assign imem_addr  = r_pc;
    assign dmem_req   = (r_state == S_MEM);
    assign dmem_we    = dmem_req && (w_op == OP_SW);
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_op_a;
    assign pc_out     = r_pc;
    assign halted     = (r_state == S_HALT);

`ifdef PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_retired_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cycle_cnt   <= '0;
            r_retired_cnt <= '0;
        end else begin
            if (r_state != S_HALT) r_cycle_cnt   <= r_cycle_cnt + 32'd1;
            if (r_state == S_WB)   r_retired_cnt <= r_retired_cnt + 32'd1;
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign retired_cnt = r_retired_cnt;
`endif

endmodule
